// File: rtl/imm_extend_stage_if.sv
// imm_extend_stage_if: valid/ready bundle between the decoder, the extension stage and its consumer
interface imm_extend_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  modport master (output in_valid, in_imm, in_mode, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_imm, in_mode, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extension (zero/sign/upper/branch) behind a 2-entry skid FIFO
module imm_extend_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  imm_extend_stage_if.slave bus,
  output logic [1:0]        occupancy
);
  localparam int PAD_W = OUT_W - IN_W;
  logic [OUT_W-1:0] r_mem [2];
  logic             r_rd;
  logic             r_wr;
  logic [1:0]       r_cnt;
  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_ext;
  logic             w_push;
  logic             w_pop;
  // Extend the raw field by mode; the extended value is what gets stored
  always_comb begin
    w_sext = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
    w_ext  = bus.in_mode == 2'd0 ? {{PAD_W{1'b0}}, bus.in_imm}
           : bus.in_mode == 2'd1 ? w_sext
           : bus.in_mode == 2'd2 ? {bus.in_imm, {PAD_W{1'b0}}}
           : {w_sext[OUT_W-3:0], 2'b00};
  end
  assign bus.in_ready  = (r_cnt != 2'd2) & ~flush;
  assign bus.out_valid = r_cnt != 2'd0;
  assign bus.out_data  = r_mem[r_rd];
  assign occupancy     = r_cnt;
  assign w_push        = bus.in_valid & bus.in_ready;
  assign w_pop         = bus.out_valid & bus.out_ready;
  // FIFO storage, pointers and count; flush drops everything, reset also clears the data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (flush) begin
      r_rd  <= r_wr;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wr] <= w_ext;
      if (w_push) r_wr <= ~r_wr;
      if (w_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: tb/tb_imm_extend_stage.sv
// tb_imm_extend_stage: directed and streaming scoreboard bench for the immediate-extension stage
module tb_imm_extend_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  occupancy;
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          n_pop = 0;
  int          n0;
  logic [1:0]  m;
  logic [15:0] v;
  imm_extend_stage_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .bus(bus.slave),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic logic [31:0] ext_model(input logic [1:0] md, input logic [15:0] im);
    int s;
    s = im[15] ? int'(im) - 65536 : int'(im);
    case (md)
      2'd0:    return {16'h0000, im};
      2'd1:    return 32'(s);
      2'd2:    return {im, 16'h0000};
      default: return 32'(s * 4);
    endcase
  endfunction
  // Monitor: pop and compare every transfer; reset and flush discard held expectations
  always @(negedge clk) begin
    if (reset) exp_q.delete();
    else begin
      if (bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", bus.out_data);
        end else check("scoreboard", bus.out_data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
    end
  end
  task automatic offer(input logic [1:0] md, input logic [15:0] im, input logic [31:0] e);
    bus.in_valid = 1'b1;
    bus.in_mode  = md;
    bus.in_imm   = im;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    errors++;
    $display("FAIL offer_timeout: got in_ready=0 for 20 cycles expected acceptance of %h", e);
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (occupancy != 2'd0 && i < 20);
    check("drain_occ", 32'(occupancy), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_imm    = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    offer(2'd0, 16'h9000, 32'h00009000);
    @(negedge clk);
    check("latency_valid", 32'(bus.out_valid), 32'd1);
    check("latency_data", bus.out_data, 32'h00009000);
    @(posedge clk);
    #1;
    offer(2'd1, 16'h9000, 32'hFFFF9000);
    offer(2'd1, 16'h7FFF, 32'h00007FFF);
    offer(2'd2, 16'h0001, 32'h00010000);
    offer(2'd3, 16'hFFFF, 32'hFFFFFFFC);
    offer(2'd3, 16'h4000, 32'h00010000);
    drain();
    bus.out_ready = 1'b0;
    offer(2'd1, 16'h8001, 32'hFFFF8001);
    offer(2'd2, 16'h1234, 32'h12340000);
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'd3;
    bus.in_imm   = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(bus.in_ready), 32'd0);
      check("full_occ", 32'(occupancy), 32'd2);
      check("stall_data", bus.out_data, 32'hFFFF8001);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("ready_indep_of_out_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    offer(2'd3, 16'h0001, 32'h00000004);
    drain();
    bus.out_ready = 1'b0;
    offer(2'd0, 16'h1111, 32'h00001111);
    offer(2'd0, 16'h2222, 32'h00002222);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h3333;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_occ", 32'(occupancy), 32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    offer(2'd1, 16'hABCD, 32'hFFFFABCD);
    bus.in_valid = 1'b1;
    bus.in_imm   = 16'h5555;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_occ", 32'(occupancy), 32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_data", bus.out_data, 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    n0 = n_pop;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      m = 2'($urandom_range(0, 3));
      v = 16'($urandom);
      bus.in_mode = m;
      bus.in_imm  = v;
      @(negedge clk);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      if (bus.in_ready) exp_q.push_back(ext_model(m, v));
      if (i > 0) check("stream_out_valid", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();
    check("stream_count", 32'(n_pop - n0), 32'd1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
